// File: rtl/ibex_wb_scoreboard.sv
// In-order writeback scoreboard for up to DEPTH outstanding LSU/multdiv ops: hazard stall, RF write enables, retire count.
// EX ops retire in the accept cycle and queued ops retire in their strobe cycle; issue stalls on a hazard, or when full (or non-empty for EX).
module ibex_wb_scoreboard #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [1:0]               issue_unit_i,
  input  logic                     issue_we_i,
  input  logic [4:0]               issue_rd_i,
  input  logic [4:0]               issue_rs1_i,
  input  logic [4:0]               issue_rs2_i,
  input  logic                     issue_rs1_used_i,
  input  logic                     issue_rs2_used_i,
  input  logic                     issue_compressed_i,
  input  logic                     lsu_valid_i,
  input  logic                     lsu_err_i,
  input  logic                     ex_valid_i,
  output logic                     hazard_o,
  output logic                     wb_we_o,
  output logic [4:0]               wb_waddr_o,
  output logic [1:0]               wb_sel_o,
  output logic                     wb_err_o,
  output logic                     instr_ret_o,
  output logic                     instr_ret_compressed_o,
  output logic [CNT_W-1:0]         ret_count_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] UNIT_LSU = 2'd1;
  localparam logic [1:0] UNIT_MD  = 2'd2;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic [1:0] unit;
    logic       compressed;
  } sb_entry_t;

  sb_entry_t        q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [CNT_W-1:0] ret_cnt_q;

  sb_entry_t head_e;
  sb_entry_t new_e;
  logic      issue_ex;
  logic      hit;
  logic      issue_fire;
  logic      ex_ret;
  logic      head_done;
  logic      head_lsu_err;
  logic      push;
  logic      pop;

  assign head_e   = q[head_q];
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign issue_ex = (issue_unit_i != UNIT_LSU) && (issue_unit_i != UNIT_MD);

  // No bypass: a head completing this cycle still blocks a dependent issue.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && q[i].we && (q[i].rd != 5'd0) &&
          ((issue_rs1_used_i && (issue_rs1_i == q[i].rd)) ||
           (issue_rs2_used_i && (issue_rs2_i == q[i].rd)) ||
           (issue_we_i       && (issue_rd_i  == q[i].rd)))) begin
        hit = 1'b1;
      end
    end
  end

  assign hazard_o      = issue_valid_i & hit;
  assign issue_ready_o = !flush_i && !hazard_o && (issue_ex ? empty_o : !full_o);
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign ex_ret        = issue_fire & issue_ex & !rst_i;
  assign head_done     = !rst_i && !flush_i && !empty_o &&
                         (((head_e.unit == UNIT_LSU) && lsu_valid_i) ||
                          ((head_e.unit == UNIT_MD)  && ex_valid_i));
  assign head_lsu_err  = (head_e.unit == UNIT_LSU) && lsu_err_i;
  assign push          = issue_fire & !issue_ex;
  assign pop           = head_done;

  always_comb begin
    wb_we_o                = 1'b0;
    wb_err_o               = 1'b0;
    instr_ret_o            = 1'b0;
    instr_ret_compressed_o = 1'b0;
    wb_waddr_o             = (empty_o || flush_i) ? 5'd0 : head_e.rd;
    wb_sel_o               = (empty_o || flush_i) ? 2'd0 : head_e.unit;
    if (ex_ret) begin
      wb_we_o                = issue_we_i && (issue_rd_i != 5'd0);
      wb_waddr_o             = issue_rd_i;
      wb_sel_o               = 2'd0;
      instr_ret_o            = 1'b1;
      instr_ret_compressed_o = issue_compressed_i;
    end else if (head_done) begin
      wb_we_o                = head_e.we && (head_e.rd != 5'd0) && !head_lsu_err;
      wb_err_o               = head_lsu_err;
      instr_ret_o            = !head_lsu_err;
      instr_ret_compressed_o = !head_lsu_err && head_e.compressed;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        vld_q   <= '0;
      end else begin
        if (push) begin
          tail_q         <= tail_q + PW'(1);
          vld_q[tail_q]  <= 1'b1;
        end
        if (pop) begin
          head_q         <= head_q + PW'(1);
          vld_q[head_q]  <= 1'b0;
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      ret_cnt_q <= ret_cnt_q + CNT_W'(instr_ret_o);
    end
  end

  assign new_e = '{rd: issue_rd_i, we: issue_we_i, unit: issue_unit_i, compressed: issue_compressed_i};

  // Payload needs no reset: vld_q and count_q gate every use of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q[tail_q] <= new_e;
    end
  end

  assign ret_count_o   = ret_cnt_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_ibex_wb_scoreboard.sv
// Randomized and directed bench for ibex_wb_scoreboard against a queue-based reference model.
module tb_ibex_wb_scoreboard;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk_i = 1'b0;
  logic rst_i, flush_i, issue_valid_i, issue_ready_o;
  logic [1:0] issue_unit_i;
  logic issue_we_i;
  logic [4:0] issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic issue_rs1_used_i, issue_rs2_used_i, issue_compressed_i;
  logic lsu_valid_i, lsu_err_i, ex_valid_i;
  logic hazard_o, wb_we_o, wb_err_o, instr_ret_o, instr_ret_compressed_o;
  logic [4:0] wb_waddr_o;
  logic [1:0] wb_sel_o;
  logic [CNT_W-1:0] ret_count_o;
  logic [$clog2(DEPTH):0] outstanding_o;
  logic empty_o, full_o;

  always #5 clk_i = ~clk_i;

  ibex_wb_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_unit_i(issue_unit_i), .issue_we_i(issue_we_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs1_used_i(issue_rs1_used_i), .issue_rs2_used_i(issue_rs2_used_i),
    .issue_compressed_i(issue_compressed_i),
    .lsu_valid_i(lsu_valid_i), .lsu_err_i(lsu_err_i), .ex_valid_i(ex_valid_i),
    .hazard_o(hazard_o), .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_sel_o(wb_sel_o),
    .wb_err_o(wb_err_o), .instr_ret_o(instr_ret_o),
    .instr_ret_compressed_o(instr_ret_compressed_o), .ret_count_o(ret_count_o),
    .outstanding_o(outstanding_o), .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic [1:0] unit;
    logic       comp;
  } ment_t;

  ment_t mq[$];
  int    cnt;
  int    n_checks = 0;
  int    n_errors = 0;

  logic e_haz, e_rdy, e_we, e_err, e_ret, e_retc, e_fire, e_ex, e_done;
  logic [4:0] e_waddr;
  logic [1:0] e_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_unit_i = 2'd0;
    issue_we_i = 1'b0; issue_rd_i = 5'd0; issue_rs1_i = 5'd0; issue_rs2_i = 5'd0;
    issue_rs1_used_i = 1'b0; issue_rs2_used_i = 1'b0; issue_compressed_i = 1'b0;
    lsu_valid_i = 1'b0; lsu_err_i = 1'b0; ex_valid_i = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] unit, input logic we, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic comp);
    issue_valid_i = 1'b1; issue_unit_i = unit; issue_we_i = we; issue_rd_i = rd;
    issue_rs1_i = rs1; issue_rs1_used_i = u1; issue_rs2_i = rs2; issue_rs2_used_i = u2;
    issue_compressed_i = comp;
  endtask

  // Expected combinational outputs straight from the retirement rules.
  task automatic settle();
    logic lerr;
    #1;
    e_ex  = (issue_unit_i == 2'd0) || (issue_unit_i == 2'd3);
    e_haz = 1'b0;
    if (issue_valid_i)
      foreach (mq[i])
        if (mq[i].we && mq[i].rd != 0 &&
            ((issue_rs1_used_i && issue_rs1_i == mq[i].rd) ||
             (issue_rs2_used_i && issue_rs2_i == mq[i].rd) ||
             (issue_we_i && issue_rd_i == mq[i].rd)))
          e_haz = 1'b1;
    e_rdy  = !flush_i && !e_haz && (e_ex ? (mq.size() == 0) : (mq.size() < DEPTH));
    e_fire = issue_valid_i && e_rdy;
    e_done = !rst_i && !flush_i && mq.size() > 0 &&
             ((mq[0].unit == 2'd1 && lsu_valid_i) || (mq[0].unit == 2'd2 && ex_valid_i));
    e_we = 0; e_err = 0; e_ret = 0; e_retc = 0;
    e_waddr = (mq.size() > 0) ? mq[0].rd : 5'd0;
    e_sel   = (mq.size() > 0) ? mq[0].unit : 2'd0;
    if (e_fire && e_ex && !rst_i) begin
      e_ret = 1; e_we = issue_we_i && issue_rd_i != 0; e_waddr = issue_rd_i;
      e_sel = 0; e_retc = issue_compressed_i;
    end else if (e_done) begin
      lerr = (mq[0].unit == 2'd1) && lsu_err_i;
      e_we = mq[0].we && mq[0].rd != 0 && !lerr; e_err = lerr;
      e_ret = !lerr; e_retc = !lerr && mq[0].comp;
    end
    check("hazard", 32'(hazard_o), 32'(e_haz));
    check("ready", 32'(issue_ready_o), 32'(e_rdy));
    check("wb_we", 32'(wb_we_o), 32'(e_we));
    check("wb_err", 32'(wb_err_o), 32'(e_err));
    check("ret", 32'(instr_ret_o), 32'(e_ret));
    check("ret_c", 32'(instr_ret_compressed_o), 32'(e_retc));
    if (!flush_i) begin
      check("wb_waddr", 32'(wb_waddr_o), 32'(e_waddr));
      check("wb_sel", 32'(wb_sel_o), 32'(e_sel));
    end
  endtask

  task automatic tick();
    ment_t n;
    @(posedge clk_i);
    if (rst_i) begin
      mq.delete(); cnt = 0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      if (e_done) void'(mq.pop_front());
      if (e_fire && !e_ex) begin
        n.rd = issue_rd_i; n.we = issue_we_i; n.unit = issue_unit_i; n.comp = issue_compressed_i;
        mq.push_back(n);
      end
      if (e_ret) cnt = (cnt + 1) % (1 << CNT_W);
    end
    #1;
    check("outstanding", 32'(outstanding_o), 32'(mq.size()));
    check("empty", 32'(empty_o), 32'(mq.size() == 0));
    check("full", 32'(full_o), 32'(mq.size() == DEPTH));
    check("ret_count", 32'(ret_count_o), 32'(cnt));
  endtask

  initial begin
    int saved;
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    mq.delete(); cnt = 0;
    #1;
    idle();
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_outstanding", 32'(outstanding_o), 0);
    check("rst_count", 32'(ret_count_o), 0);
    settle();
    check("rst_ready", 32'(issue_ready_o), 1);
    tick();

    // EX retire in the accept cycle
    set_issue(2'd0, 1, 5'd5, 0, 0, 0, 0, 0);
    settle();
    check("ex_we", 32'(wb_we_o), 1);
    check("ex_waddr", 32'(wb_waddr_o), 5);
    check("ex_ret", 32'(instr_ret_o), 1);
    tick();
    check("ex_cnt", 32'(ret_count_o), 1);

    // In-order completion; strobe for a non-head unit ignored
    idle(); set_issue(2'd1, 1, 5'd3, 0, 0, 0, 0, 0); settle(); tick();
    idle(); set_issue(2'd2, 1, 5'd4, 0, 0, 0, 0, 0); settle(); tick();
    idle(); ex_valid_i = 1; settle();
    check("ooo_ignored", 32'(instr_ret_o), 0);
    tick();
    idle(); lsu_valid_i = 1; settle();
    check("lsu_waddr", 32'(wb_waddr_o), 3);
    check("lsu_sel", 32'(wb_sel_o), 1);
    tick();
    idle(); ex_valid_i = 1; settle();
    check("md_waddr", 32'(wb_waddr_o), 4);
    check("md_sel", 32'(wb_sel_o), 2);
    tick();
    check("two_ret_cnt", 32'(ret_count_o), 3);

    // RAW hazard, no bypass, then release; rd=0 never hazards
    idle(); set_issue(2'd1, 1, 5'd7, 0, 0, 0, 0, 0); settle(); tick();
    idle(); set_issue(2'd2, 1, 5'd8, 0, 0, 5'd7, 1, 0); settle();
    check("haz_on", 32'(hazard_o), 1);
    check("haz_rdy", 32'(issue_ready_o), 0);
    tick();
    lsu_valid_i = 1; settle();
    check("haz_nobypass", 32'(hazard_o), 1);
    tick();
    lsu_valid_i = 0; settle();
    check("haz_off", 32'(hazard_o), 0);
    check("haz_accept", 32'(issue_ready_o), 1);
    tick();
    idle(); ex_valid_i = 1; settle(); tick();
    idle(); set_issue(2'd1, 1, 5'd0, 0, 0, 0, 0, 0); settle(); tick();
    idle(); set_issue(2'd2, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0); settle();
    check("rd0_nohaz", 32'(hazard_o), 0);
    tick();

    // Full: pop plus offer in the same cycle, offer rejected
    idle(); set_issue(2'd1, 1, 5'd10, 0, 0, 0, 0, 0); lsu_valid_i = 1; settle();
    check("full_rej", 32'(issue_ready_o), 0);
    check("full_pop", 32'(instr_ret_o), 1);
    tick();
    check("full_outst", 32'(outstanding_o), 1);
    idle(); ex_valid_i = 1; settle(); tick();

    // LSU error
    idle(); set_issue(2'd1, 1, 5'd9, 0, 0, 0, 0, 0); settle(); tick();
    idle(); lsu_valid_i = 1; lsu_err_i = 1; settle();
    check("err_we", 32'(wb_we_o), 0);
    check("err_err", 32'(wb_err_o), 1);
    check("err_ret", 32'(instr_ret_o), 0);
    tick();

    // Flush and reset discard pending entries
    for (int k = 0; k < 2; k++) begin
      idle(); set_issue(2'd1, 1, 5'd11, 0, 0, 0, 0, 0); settle(); tick();
      idle(); set_issue(2'd2, 1, 5'd12, 0, 0, 0, 0, 0); settle(); tick();
      idle(); lsu_valid_i = 1;
      if (k == 0) flush_i = 1; else rst_i = 1;
      settle();
      check("drop_ret", 32'(instr_ret_o), 0);
      check("drop_we", 32'(wb_we_o), 0);
      tick();
      check("drop_empty", 32'(empty_o), 1);
    end

    // Counter wrap over 16 EX retires
    saved = cnt;
    for (int i = 0; i < 16; i++) begin
      idle(); set_issue(2'd0, 1, 5'($urandom_range(31)), 0, 0, 0, 0, (i == 3));
      settle();
      if (i == 3) check("ret_comp", 32'(instr_ret_compressed_o), 1);
      tick();
    end
    check("wrap", 32'(ret_count_o), 32'(saved));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_i = ($urandom_range(99) == 0);
      flush_i = ($urandom_range(24) == 0);
      if ($urandom_range(2) != 0)
        set_issue(2'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(7)),
                  5'($urandom_range(7)), 1'($urandom_range(1)), 5'($urandom_range(7)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
      lsu_valid_i = ($urandom_range(2) == 0);
      lsu_err_i = ($urandom_range(3) == 0);
      ex_valid_i = ($urandom_range(2) == 0);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
